// File: rtl/modmul_pkg.sv
// Shared constants and FSM state type for the 256-bit modular multiplier and its result unloader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modmul_pkg;

    localparam int DATA_W = 256;
    localparam int WORD_W = 32;
    localparam int NWORDS = DATA_W / WORD_W;
    localparam int IW     = $clog2(NWORDS);

    // Unloader FSM: IDLE presents nothing, SEND presents one word per handshake
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/modmul_result_fifo.sv
// Synchronous result FIFO: DEPTH entries of DATA_W bits, combinational head, registered level.
// Latency: a push is visible at head/level on the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle (then both occur).
module modmul_result_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [DATA_W-1:0]        head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign push_ok = push_i && (!full_o || pop_ok);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage: data only, never read while empty so it needs no reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/modmul_result_unloader.sv
// Buffers modmul results and streams each as DATA_W/WORD_W words; MODMUL_UNLOAD_MSW_FIRST_EN selects MSW-first order.
// Latency: in_valid in cycle n -> level=1 in n+1 -> first word valid in n+2; one word per cycle, no bubble between results.
// Backpressure: out_ready stalls the word stream; input has none, so a push into a full buffer without a pop is dropped and sets sticky overflow.
module modmul_result_unloader #(
    parameter int DATA_W = modmul_pkg::DATA_W,
    parameter int WORD_W = modmul_pkg::WORD_W,
    parameter int DEPTH  = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [DATA_W-1:0]                     Q_in,
    output logic [WORD_W-1:0]                     out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic [$clog2(DATA_W/WORD_W)-1:0]      out_index,
    output logic                                  busy,
    output logic                                  overflow,
    output logic [$clog2(DEPTH):0]                level
);

    import modmul_pkg::*;

    localparam int NW   = DATA_W / WORD_W;
    localparam int IDXW = $clog2(NW);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NW - 1);

    state_e                    state_q, state_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic                      overflow_q, overflow_d;
    logic [IDXW-1:0]           word_sel;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [LW-1:0]             fifo_level;
    logic [DATA_W-1:0]         fifo_head;
    logic [NW-1:0][WORD_W-1:0] head_words;
    logic                      send;
    logic                      hs;
    logic                      last_word;
    logic                      pop;

    assign send      = (state_q == SEND);
    assign hs        = send && out_ready;
    assign last_word = send && (idx_q == LAST_IDX);
    // The head leaves only when its final word is accepted
    assign pop       = hs && last_word;

    modmul_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (in_valid),
        .wdata_i (Q_in),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .head_o  (fifo_head)
    );

    assign head_words = fifo_head;

`ifdef MODMUL_UNLOAD_MSW_FIRST_EN
    // Most-significant word first; out_index still counts up from 0
    assign word_sel = LAST_IDX - idx_q;
`else
    // Least-significant word first
    assign word_sel = idx_q;
`endif

    // Data is forced to zero outside SEND so an empty/reset buffer never shows stale storage
    assign out_data  = send ? head_words[word_sel] : '0;
    assign out_valid = send;
    assign out_last  = last_word;
    assign out_index = idx_q;
    assign busy      = !fifo_empty;
    assign level     = fifo_level;
    assign overflow  = overflow_q;

    // FSM and word counter next-state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (last_word) begin
                        idx_d = '0;
                        // Keep streaming if an entry survives the pop, including one pushed this cycle
                        if ((fifo_level <= LW'(1)) && !in_valid) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sticky drop flag: a push that found the buffer full with no pop to make room
    always_comb begin
        overflow_d = overflow_q || (in_valid && fifo_full && !pop);
    end

    // Control registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_modmul_result_unloader.sv
// Bench for modmul_result_unloader: directed scenarios plus random traffic against a queue-based reference.
// Latency: reference predicts each edge from the inputs in force, outputs sampled on the falling edge.
// Backpressure: out_ready randomised or patterned; reference tracks drops and sticky overflow.
module tb_modmul_result_unloader;

    localparam int NW    = 8;
    localparam int DEPTH = 2;
    localparam logic [255:0] KQ =
        256'h972a846916419f828b9d2434e465e150bd9c66b3ad3c2d6d1a3d1fa7bc8960a9;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [255:0] Q_in;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [2:0]   out_index;
    logic         busy;
    logic         overflow;
    logic [1:0]   level;

    modmul_result_unloader dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .Q_in      (Q_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index),
        .busy      (busy),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clock = ~clock;

    // Reference state: queued results (head is being sent), word position, streaming flag, drop flag
    logic [255:0] mq[$];
    bit           msend;
    int           midx;
    bit           movf;
    logic [31:0]  hs_words[$];
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [255:0] q, input int i);
`ifdef MODMUL_UNLOAD_MSW_FIRST_EN
        return q[(NW-1-i)*32 +: 32];
`else
        return q[i*32 +: 32];
`endif
    endfunction

    // Predict the effect of the coming rising edge from the inputs now in force
    task automatic model_edge();
        bit           hs;
        bit           pop;
        int           sz0;
        logic [255:0] dummy;
        sz0 = mq.size();
        hs  = msend && out_ready;
        pop = hs && (midx == NW-1);
        if (out_valid && out_ready) hs_words.push_back(out_data);
        if (pop) dummy = mq.pop_front();
        if (in_valid) begin
            if (sz0 < DEPTH || pop) mq.push_back(Q_in);
            else movf = 1'b1;
        end
        if (!msend) begin
            msend = (sz0 != 0);
        end else if (hs) begin
            if (midx == NW-1) begin
                midx  = 0;
                msend = (mq.size() != 0);
            end else begin
                midx++;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 256'(out_valid), 256'(msend));
        chk("level", 256'(level), 256'(mq.size()));
        chk("busy", 256'(busy), 256'(mq.size() != 0));
        chk("overflow", 256'(overflow), 256'(movf));
        if (msend) begin
            chk("out_data", 256'(out_data), 256'(mword(mq[0], midx)));
            chk("out_index", 256'(out_index), 256'(midx));
            chk("out_last", 256'(out_last), 256'(midx == NW-1));
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge clock);
        compare();
    endtask

    // Asynchronous reset raised between edges; outputs must clear before any clock edge
    task automatic do_reset();
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_last", 256'(out_last), 256'(0));
        chk("rst_out_index", 256'(out_index), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_overflow", 256'(overflow), 256'(0));
        chk("rst_level", 256'(level), 256'(0));
        mq.delete();
        msend = 1'b0;
        midx  = 0;
        movf  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        compare();
    endtask

    initial begin
        bit pushed;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Q_in      = '0;
        do_reset();

        // Single result with out_ready high
        hs_words.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Q_in      = KQ;
        tick();
        in_valid  = 1'b0;
        repeat (12) tick();
        chk("t1_count", 256'(hs_words.size()), 256'(8));
`ifdef MODMUL_UNLOAD_MSW_FIRST_EN
        chk("t1_first", 256'(hs_words[0]), 256'(32'h972a8469));
        chk("t1_last", 256'(hs_words[7]), 256'(32'hbc8960a9));
`else
        chk("t1_first", 256'(hs_words[0]), 256'(32'hbc8960a9));
        chk("t1_second", 256'(hs_words[1]), 256'(32'h1a3d1fa7));
        chk("t1_last", 256'(hs_words[7]), 256'(32'h972a8469));
`endif
        chk("t1_busy", 256'(busy), 256'(0));

        // Backpressure with out_ready pattern 1,0,0
        hs_words.delete();
        in_valid = 1'b1;
        Q_in     = KQ;
        for (int i = 0; i < 40; i++) begin
            out_ready = ((i % 3) == 0);
            tick();
            in_valid = 1'b0;
        end
        chk("t2_count", 256'(hs_words.size()), 256'(8));
        for (int i = 0; i < 8; i++) chk("t2_word", 256'(hs_words[i]), 256'(mword(KQ, i)));

        // Push on the final handshake while full
        do_reset();
        hs_words.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        Q_in      = 256'hA0;
        tick();
        Q_in      = 256'hB0;
        tick();
        in_valid  = 1'b0;
        repeat (3) tick();
        chk("t4_full_level", 256'(level), 256'(2));
        out_ready = 1'b1;
        pushed    = 1'b0;
        for (int i = 0; i < 20 && !pushed; i++) begin
            if (msend && midx == NW-1) begin
                in_valid = 1'b1;
                Q_in     = 256'hC0;
                pushed   = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        chk("t4_level_kept", 256'(level), 256'(2));
        chk("t4_no_overflow", 256'(overflow), 256'(0));
        repeat (30) tick();
        chk("t4_count", 256'(hs_words.size()), 256'(24));
        chk("t4_third_result", 256'(hs_words[16]), 256'(mword(256'hC0, 0)));

        // Overflow: three pulses into a stalled two-entry buffer
        do_reset();
        hs_words.delete();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            Q_in     = 256'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t3_level", 256'(level), 256'(2));
        chk("t3_overflow", 256'(overflow), 256'(1));
        out_ready = 1'b1;
        repeat (30) tick();
        chk("t3_count", 256'(hs_words.size()), 256'(16));
        chk("t3_r1_w0", 256'(hs_words[0]), 256'(mword(256'd1, 0)));
        chk("t3_r2_w0", 256'(hs_words[8]), 256'(mword(256'd2, 0)));

        // Reset in the middle of a transfer
        do_reset();
        hs_words.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Q_in      = KQ;
        tick();
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && hs_words.size() < 3; i++) tick();
        chk("t5_hs_before_reset", 256'(hs_words.size()), 256'(3));
        do_reset();
        out_ready = 1'b1;
        repeat (10) tick();
        chk("t5_no_words", 256'(out_valid), 256'(0));

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 8; k++) Q_in[k*32 +: 32] = $urandom();
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        chk("rand_drained", 256'(level), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
